// File: rtl/psram_qpi_model_if.sv
// Pin bundle between a QPI PSRAM controller (master) and the memory model (slave).
// Protocol: there is no valid/ready pair. A frame is the interval with ce_n low;
// the controller changes dio_i while sck is low and the memory samples it on
// each sck rise, while during a read the memory changes dio_o on each sck fall
// so the controller can sample it on the next rise.
interface psram_qpi_model_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] dio_i;
  logic [3:0] dio_o;
  logic [3:0] dio_oe;
  logic       qpi;

  modport master (
    output sck, ce_n, dio_i,
    input  dio_o, dio_oe, qpi
  );

  modport slave (
    input  sck, ce_n, dio_i,
    output dio_o, dio_oe, qpi
  );
endinterface

// File: rtl/psram_qpi_model.sv
// Behavioural-but-synthesizable QPI/SPI PSRAM: 0xEB quad read, 0x38 quad write,
// 0x35 / 0xF5 enter / leave QPI command mode. sck is oversampled by clock.
module psram_qpi_model #(
  parameter int DEPTH     = 4096,
  parameter int READ_WAIT = 6
) (
  input  logic              clock,
  input  logic              reset,
  psram_qpi_model_if.slave  bus,
  output logic [2:0]        dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_WRITE = 3'd5,
    S_DROP  = 3'd6
  } state_t;

  state_t        state;
  logic          sck_q;
  logic          armed;     // set once ce_n is seen high; blocks frames already running at reset release
  logic          qpi_q;
  logic          oe_q;
  logic          half;      // 0: next nibble is [7:4], 1: next nibble is [3:0]
  logic          is_read;
  logic          wr_pend;   // completed byte waiting to be committed this cycle
  logic [3:0]    cnt;
  logic [3:0]    dio_q;
  logic [3:0]    wr_hi;
  logic [7:0]    wr_byte;
  logic [6:0]    cmd_sr;
  logic [AW-5:0] addr_sr;   // only the low address bits are kept; higher nibbles fall off the top
  logic [AW-1:0] ptr;
  logic [7:0]    mem [DEPTH];

  logic          rise;
  logic          fall;
  logic          take;
  logic          drive;
  logic [3:0]    cnt_inc;
  logic [3:0]    cmd_len;
  logic [7:0]    cmd_next;
  logic [AW-1:0] addr_next;
  logic [7:0]    rd_byte;

  // sck edge detection and next-value helpers for the shift registers
  always_comb begin
    rise      = bus.sck & ~sck_q;
    fall      = ~bus.sck & sck_q;
    take      = rise & ~bus.ce_n;
    drive     = fall & ~bus.ce_n;
    cnt_inc   = cnt + 4'd1;
    cmd_len   = qpi_q ? 4'd2 : 4'd8;
    cmd_next  = qpi_q ? {cmd_sr[3:0], bus.dio_i} : {cmd_sr, bus.dio_i[0]};
    addr_next = {addr_sr, bus.dio_i};
    rd_byte   = mem[ptr];
  end

  // frame sequencer: command, address, dummy, data phases and registered pin outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sck_q   <= 1'b0;
      armed   <= 1'b0;
      qpi_q   <= 1'b0;
      oe_q    <= 1'b0;
      half    <= 1'b0;
      is_read <= 1'b0;
      wr_pend <= 1'b0;
      cnt     <= 4'd0;
      dio_q   <= 4'd0;
      wr_hi   <= 4'd0;
      wr_byte <= 8'd0;
      cmd_sr  <= 7'd0;
      addr_sr <= '0;
      ptr     <= '0;
    end else begin
      sck_q   <= bus.sck;
      wr_pend <= 1'b0;
      // the memory block commits the pending byte this cycle; advance past it
      if (wr_pend) ptr <= ptr + AW'(1);

      if (bus.ce_n) begin
        state <= S_IDLE;
        cnt   <= 4'd0;
        half  <= 1'b0;
        oe_q  <= 1'b0;
        dio_q <= 4'd0;
        armed <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (take && armed) begin
              state  <= S_CMD;
              cmd_sr <= cmd_next[6:0];
              cnt    <= 4'd1;
            end
          end

          S_CMD: begin
            if (take) begin
              cmd_sr <= cmd_next[6:0];
              cnt    <= cnt_inc;
              if (cnt_inc == cmd_len) begin
                cnt <= 4'd0;
                case (cmd_next)
                  8'hEB: begin state <= S_ADDR; is_read <= 1'b1; end
                  8'h38: begin state <= S_ADDR; is_read <= 1'b0; end
                  8'h35: begin state <= S_DROP; qpi_q <= 1'b1; end
                  8'hF5: begin state <= S_DROP; qpi_q <= 1'b0; end
                  default: state <= S_DROP;
                endcase
              end
            end
          end

          S_ADDR: begin
            if (take) begin
              addr_sr <= addr_next[AW-5:0];
              cnt     <= cnt_inc;
              if (cnt_inc == 4'd6) begin
                cnt   <= 4'd0;
                ptr   <= addr_next;
                half  <= 1'b0;
                state <= is_read ? S_WAIT : S_WRITE;
              end
            end
          end

          S_WAIT: begin
            if (take) begin
              cnt <= cnt_inc;
              if (cnt_inc == 4'(READ_WAIT)) begin
                cnt   <= 4'd0;
                state <= S_READ;
              end
            end
          end

          S_READ: begin
            if (drive) begin
              oe_q <= 1'b1;
              if (!half) begin
                dio_q <= rd_byte[7:4];
                half  <= 1'b1;
              end else begin
                dio_q <= rd_byte[3:0];
                half  <= 1'b0;
                ptr   <= ptr + AW'(1);
              end
            end
          end

          S_WRITE: begin
            if (take) begin
              if (!half) begin
                wr_hi <= bus.dio_i;
                half  <= 1'b1;
              end else begin
                wr_byte <= {wr_hi, bus.dio_i};
                wr_pend <= 1'b1;
                half    <= 1'b0;
              end
            end
          end

          S_DROP: begin
            oe_q <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // storage array: no reset so contents survive reset; only whole bytes are committed
  always_ff @(posedge clock) begin
    if (wr_pend) mem[ptr] <= wr_byte;
  end

  assign bus.dio_o  = dio_q;
  assign bus.dio_oe = {4{oe_q}};
  assign bus.qpi    = qpi_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_psram_qpi_model.sv
// Directed bench for psram_qpi_model: a byte-array model of the memory plus
// expected pin values, a per-cycle compare process, and literal read-back pins.
module tb_psram_qpi_model;

  localparam int DEPTH = 4096;
  localparam int RW    = 6;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  psram_qpi_model_if bus();
  logic [2:0] dbg_state;

  psram_qpi_model #(.DEPTH(DEPTH), .READ_WAIT(RW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- model and scoreboard state ----------------
  logic [7:0] exp_mem [DEPTH];
  bit         exp_qpi;
  bit         exp_oe;
  logic [3:0] exp_dio;
  logic [3:0] exp_q[$];    // expected read nibbles of the current read frame
  logic [3:0] got_q[$];    // nibbles observed on dio_o
  logic [3:0] stim_q[$];   // write data nibbles
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // nibble k of a read burst starting at addr, straight from the byte model
  function automatic logic [3:0] model_nib(input int addr, input int k);
    logic [7:0] b;
    b = exp_mem[(addr + k / 2) % DEPTH];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  // per-cycle compare, sampled on the falling clock edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("qpi", 32'(bus.qpi), 32'(exp_qpi));
      check("dio_oe", 32'(bus.dio_oe), 32'({4{exp_oe}}));
      if (exp_oe) check("dio_o", 32'(bus.dio_o), 32'(exp_dio));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rise(input logic [3:0] d);
    bus.dio_i = d;
    bus.sck   = 1'b1;
    tick();
  endtask

  task automatic fall();
    bus.sck = 1'b0;
    tick();
  endtask

  task automatic hold();
    repeat (3) tick();
  endtask

  task automatic begin_frame();
    bus.ce_n = 1'b0;
    hold();
  endtask

  task automatic end_frame();
    bus.ce_n = 1'b1;
    tick();
    exp_oe  = 1'b0;
    bus.sck = 1'b0;
    hold();
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int n;
    logic [3:0] d;
    n = exp_qpi ? 2 : 8;
    for (int i = 0; i < n; i++) begin
      if (exp_qpi) d = (i == 0) ? c[7:4] : c[3:0];
      else         d = {3'b000, c[7 - i]};
      rise(d);
      if (i == n - 1) begin
        if (c == 8'h35) exp_qpi = 1'b1;
        else if (c == 8'hF5) exp_qpi = 1'b0;
      end
      hold();
      fall();
      hold();
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 0; i < 6; i++) begin
      rise(a[23 - 4 * i -: 4]);
      hold();
      fall();
      hold();
    end
  endtask

  task automatic cmd_frame(input logic [7:0] c);
    begin_frame();
    send_cmd(c);
    end_frame();
  endtask

  task automatic do_write(input logic [23:0] a);
    int p;
    begin_frame();
    send_cmd(8'h38);
    send_addr(a);
    p = int'(a) % DEPTH;
    for (int k = 0; k < stim_q.size(); k++) begin
      rise(stim_q[k]);
      hold();
      fall();
      hold();
      if (k % 2 == 1) begin
        exp_mem[p] = {stim_q[k - 1], stim_q[k]};
        p = (p + 1) % DEPTH;
      end
    end
    end_frame();
  endtask

  // command, address and dummy phase; the final dummy fall is the first data fall
  task automatic read_start(input logic [23:0] a);
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < RW; i++) begin
      rise(4'($urandom_range(0, 15)));
      hold();
      if (i == RW - 1) check("oe_low_through_last_dummy", 32'(bus.dio_oe), 32'h0);
      else begin
        fall();
        hold();
      end
    end
  endtask

  task automatic read_nibs(input logic [23:0] a, input int n);
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(model_nib(int'(a) % DEPTH, k));
    for (int k = 0; k < n; k++) begin
      fall();
      exp_oe  = 1'b1;
      exp_dio = exp_q[k];
      got_q.push_back(bus.dio_o);
      hold();
      rise(4'($urandom_range(0, 15)));
      hold();
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    begin_frame();
    read_start(a);
    read_nibs(a, n);
    end_frame();
  endtask

  // hand-computed pins on the first four observed nibbles
  task automatic expect_nibs(input string name, input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check(name, 32'(got_q[i]), 32'(v[15 - 4 * i -: 4]));
      else check(name, 32'hdead, 32'(v[15 - 4 * i -: 4]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] stray;
    bus.sck   = 1'b0;
    bus.ce_n  = 1'b1;
    bus.dio_i = 4'd0;
    exp_qpi   = 1'b0;
    exp_oe    = 1'b0;
    exp_dio   = 4'd0;

    tick();
    chk_en = 1'b1;
    hold();
    check("reset_dio_oe", 32'(bus.dio_oe), 32'h0);
    check("reset_qpi", 32'(bus.qpi), 32'h0);
    check("reset_dio_o", 32'(bus.dio_o), 32'h0);
    reset = 1'b0;
    hold();

    // SPI write then read at 0x10
    stim_q = '{4'h1, 4'h2, 4'h3, 4'h4};
    do_write(24'h000010);
    do_read(24'h000010, 4);
    expect_nibs("spi_read_0x10", 16'h1234);

    // wrap at the top of memory
    stim_q = '{4'hA, 4'hA, 4'hB, 4'hB};
    do_write(24'h000FFF);
    do_read(24'h000FFF, 4);
    expect_nibs("wrap_read_0xFFF", 16'hAABB);
    do_read(24'h000000, 2);
    check("wrap_low_byte_hi", 32'(got_q[0]), 32'hB);

    // upper address bits ignored: 0x123010 aliases 0x010
    do_read(24'h123010, 4);
    expect_nibs("alias_read", 16'h1234);

    // mode switch and QPI traffic
    cmd_frame(8'h35);
    check("qpi_after_35", 32'(bus.qpi), 32'h1);
    stim_q = '{4'h5, 4'hA, 4'hC, 4'h3};
    do_write(24'h000020);
    do_read(24'h000020, 4);
    expect_nibs("qpi_read_0x20", 16'h5AC3);
    cmd_frame(8'hF5);
    check("qpi_after_F5", 32'(bus.qpi), 32'h0);

    // unknown command: drop the frame, never drive
    begin_frame();
    send_cmd(8'h9F);
    for (int i = 0; i < 8; i++) begin
      rise(4'hF);
      hold();
      fall();
      hold();
    end
    end_frame();
    do_read(24'h000010, 4);
    expect_nibs("after_9F_0x10", 16'h1234);
    do_read(24'h000020, 4);
    expect_nibs("after_9F_0x20", 16'h5AC3);

    // odd-nibble abort leaves the next byte untouched
    stim_q = '{4'hC, 4'h3, 4'hD, 4'h4};
    do_write(24'h000200);
    stim_q = '{4'h5, 4'h6, 4'h7};
    do_write(24'h000200);
    do_read(24'h000200, 4);
    expect_nibs("abort_read_0x200", 16'h56D4);

    // reset in the middle of a QPI read
    cmd_frame(8'h35);
    check("qpi_before_reset", 32'(bus.qpi), 32'h1);
    begin_frame();
    read_start(24'h000200);
    read_nibs(24'h000200, 2);
    reset   = 1'b1;
    exp_qpi = 1'b0;
    exp_oe  = 1'b0;
    exp_dio = 4'd0;
    #1;
    check("reset_mid_read_oe", 32'(bus.dio_oe), 32'h0);
    check("reset_mid_read_qpi", 32'(bus.qpi), 32'h0);
    check("reset_mid_read_dio_o", 32'(bus.dio_o), 32'h0);
    tick();
    hold();
    reset = 1'b0;
    hold();
    // the interrupted frame continues; a 0x35 pattern inside it must be ignored
    stray = 8'h35;
    fall();
    hold();
    for (int i = 0; i < 8; i++) begin
      rise({3'b000, stray[7 - i]});
      hold();
      fall();
      hold();
    end
    end_frame();
    check("stale_frame_ignored_qpi", 32'(bus.qpi), 32'h0);

    // memory survives reset
    do_read(24'h000010, 4);
    expect_nibs("post_reset_0x10", 16'h1234);
    do_read(24'h000200, 4);
    expect_nibs("post_reset_0x200", 16'h56D4);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
